lcd_controller: RTL

Memory-mapped LCD sequencer between the CPU data bus and the character-LCD pins. The CPU posts data or command bytes into a small FIFO with single-cycle writes. The controller drains the FIFO and generates each bus transfer itself: it drives `lcd_data`/`lcd_ctrl`, waits a setup time, pulses `lcd_enable`, holds, then waits the post-write busy time. This replaces direct CPU bit-banging of the three LCD registers. It is selected when `data_addr[31]` is set, and its status is readable back on the data bus.

---
 rtl/lcd_controller_pkg.sv | 35 +++
 rtl/lcd_controller_sync_fifo.sv | 64 ++++++
 rtl/lcd_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_controller_pkg.sv
// Shared definitions for the LCD sequencer: FSM states, register offsets,
// LCD control encodings and the FIFO entry layout.
package lcd_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } lcd_state_e;

  // Register offsets within the peripheral window
  localparam logic [1:0] LCD_OFF_DATA   = 2'd0;
  localparam logic [1:0] LCD_OFF_CMD    = 2'd1;
  localparam logic [1:0] LCD_OFF_STATUS = 2'd2;
  localparam logic [1:0] LCD_OFF_CLR    = 2'd3;

  // {RS, RW}; RW is always 0 since the controller only writes
  localparam logic [1:0] LCD_CTRL_DATA = 2'b10;
  localparam logic [1:0] LCD_CTRL_CMD  = 2'b00;

  // One queued transfer: rs=1 for data, rs=0 for command
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

  localparam int unsigned LCD_ENTRY_W = $bits(lcd_entry_t);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_controller_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; push is ignored when full,
// pop is ignored when empty, and fullness is judged before a same-edge pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata_c,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [$clog2(DEPTH):0]   o_count_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count_c = r_count;
  assign o_rdata_c = r_mem[r_rd_ptr];

  assign w_do_push = i_push & ~o_full_c;
  assign w_do_pop  = i_pop & ~o_empty_c;

  // Storage array; contents only matter while counted as occupied
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_controller.sv
// Memory-mapped character-LCD sequencer: CPU writes are queued and replayed
// as setup / enable pulse / hold / busy-wait transfers on the LCD pins.
module lcd_controller
  import lcd_controller_pkg::*;
#(
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned SETUP_CYCLES     = 1,
  parameter int unsigned PULSE_CYCLES     = 2,
  parameter int unsigned HOLD_CYCLES      = 1,
  parameter int unsigned DATA_WAIT_CYCLES = 2,
  parameter int unsigned CMD_WAIT_CYCLES  = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wenable,
  input  logic [1:0]  addr,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata,
  output logic [7:0]  lcd_data,
  output logic [1:0]  lcd_ctrl,
  output logic        lcd_enable
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam int unsigned MAX_CYC = max2(max2(max2(SETUP_CYCLES, PULSE_CYCLES),
                                              max2(HOLD_CYCLES, DATA_WAIT_CYCLES)),
                                         CMD_WAIT_CYCLES);
  localparam int unsigned CTR_W   = $clog2(MAX_CYC + 1);

  // Down-counter reload values: a state lasting N cycles loads N-1
  localparam logic [CTR_W-1:0] LD_SETUP = CTR_W'(SETUP_CYCLES - 1);
  localparam logic [CTR_W-1:0] LD_PULSE = CTR_W'(PULSE_CYCLES - 1);
  localparam logic [CTR_W-1:0] LD_HOLD  = CTR_W'(HOLD_CYCLES - 1);
  localparam logic [CTR_W-1:0] LD_DWAIT = CTR_W'(DATA_WAIT_CYCLES - 1);
  localparam logic [CTR_W-1:0] LD_CWAIT = CTR_W'(CMD_WAIT_CYCLES - 1);

  lcd_state_e       r_state;
  lcd_state_e       w_state_nxt;
  logic [CTR_W-1:0] r_cnt;
  logic [CTR_W-1:0] w_cnt_nxt;
  logic [7:0]       r_lcd_data;
  logic [7:0]       w_lcd_data_nxt;
  logic [1:0]       r_lcd_ctrl;
  logic [1:0]       w_lcd_ctrl_nxt;
  logic             r_lcd_enable;
  logic             w_lcd_enable_nxt;
  logic             r_ovf;

  logic             w_push;
  logic             w_pop;
  logic             w_clr;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  lcd_entry_t       w_push_entry;
  lcd_entry_t       w_head;
  logic             w_busy;

  // Bus decode: offsets 0/1 enqueue, offset 3 clears overflow, offset 2 is read-only
  assign w_push = wenable & ((addr == LCD_OFF_DATA) | (addr == LCD_OFF_CMD));
  assign w_clr  = wenable & (addr == LCD_OFF_CLR);
  assign w_push_entry = '{rs: ~addr[0], data: wdata};

  sync_fifo #(
    .WIDTH (LCD_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wdata   (w_push_entry),
    .o_rdata_c (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count_c (w_count)
  );

  // Sticky overflow: a push against a full FIFO sets it, offset 3 clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full) begin
      r_ovf <= 1'b1;
    end else if (w_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // FSM state, phase counter and registered LCD pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_lcd_data   <= '0;
      r_lcd_ctrl   <= '0;
      r_lcd_enable <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_lcd_data   <= w_lcd_data_nxt;
      r_lcd_ctrl   <= w_lcd_ctrl_nxt;
      r_lcd_enable <= w_lcd_enable_nxt;
    end
  end

  // Next-state logic; each phase exits when its counter reaches zero
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = (r_cnt != '0) ? (r_cnt - CTR_W'(1)) : '0;
    w_lcd_data_nxt   = r_lcd_data;
    w_lcd_ctrl_nxt   = r_lcd_ctrl;
    w_lcd_enable_nxt = r_lcd_enable;
    w_pop            = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_lcd_data_nxt = w_head.data;
          w_lcd_ctrl_nxt = w_head.rs ? LCD_CTRL_DATA : LCD_CTRL_CMD;
          w_cnt_nxt      = LD_SETUP;
          w_state_nxt    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_lcd_enable_nxt = 1'b1;
          w_cnt_nxt        = LD_PULSE;
          w_state_nxt      = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_lcd_enable_nxt = 1'b0;
          w_cnt_nxt        = LD_HOLD;
          w_state_nxt      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = r_lcd_ctrl[1] ? LD_DWAIT : LD_CWAIT;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          if (!w_empty) begin
            w_pop          = 1'b1;
            w_lcd_data_nxt = w_head.data;
            w_lcd_ctrl_nxt = w_head.rs ? LCD_CTRL_DATA : LCD_CTRL_CMD;
            w_cnt_nxt      = LD_SETUP;
            w_state_nxt    = ST_SETUP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_lcd_enable_nxt = 1'b0;
      end
    endcase
  end

  assign w_busy = (r_state != ST_IDLE) | (w_count != '0);

  // Status word, combinational from current register state
  always_comb begin
    rdata           = '0;
    rdata[0]        = w_busy;
    rdata[1]        = w_full;
    rdata[2]        = r_ovf;
    rdata[8 +: CW]  = w_count;
  end

  assign lcd_data   = r_lcd_data;
  assign lcd_ctrl   = r_lcd_ctrl;
  assign lcd_enable = r_lcd_enable;

endmodule
